// File: rtl/neogeo_z80io_pkg.sv
// Shared constants for the sound-CPU I/O controller: port decode values on SDA[4:2],
// ZMC bank register reset values and the base address of each banked ROM window.
package neogeo_z80io_pkg;

  localparam logic [2:0] P_CODE    = 3'd0;
  localparam logic [2:0] P_YM      = 3'd1;
  localparam logic [2:0] P_BANK    = 3'd2;
  localparam logic [2:0] P_NMI_EN  = 3'd2;
  localparam logic [2:0] P_REPLY   = 3'd3;
  localparam logic [2:0] P_NMI_DIS = 3'd6;

  // Identity mapping of each window onto the first 64 KB of ROM
  localparam logic [7:0] BK0_RST = 8'h02;
  localparam logic [7:0] BK1_RST = 8'h06;
  localparam logic [7:0] BK2_RST = 8'h0E;
  localparam logic [7:0] BK3_RST = 8'h1E;

  localparam logic [15:0] WIN_BK0 = 16'h8000;
  localparam logic [15:0] WIN_BK1 = 16'hC000;
  localparam logic [15:0] WIN_BK2 = 16'hE000;
  localparam logic [15:0] WIN_BK3 = 16'hF000;
  localparam logic [15:0] WIN_RAM = 16'hF800;

endpackage

// File: rtl/z80_io_ctrl_if.sv
// Z80 I/O and memory-address bus as seen by the sound I/O controller.
// master = CPU wrapper side, slave = controller side.
interface z80_io_ctrl_if #(
  parameter int unsigned ROM_AW = 22
);
  logic [15:0]       SDA;
  logic [7:0]        SDD_OUT;
  logic              nIORQ;
  logic              nRD;
  logic              nWR;
  logic [7:0]        IO_DOUT;
  logic              IO_RD_ACT;
  logic              nNMI;
  logic [15:0]       MEM_A;
  logic [ROM_AW-1:0] ROM_ADDR;

  modport master (
    output SDA, SDD_OUT, nIORQ, nRD, nWR, MEM_A,
    input  IO_DOUT, IO_RD_ACT, nNMI, ROM_ADDR
  );

  modport slave (
    input  SDA, SDD_OUT, nIORQ, nRD, nWR, MEM_A,
    output IO_DOUT, IO_RD_ACT, nNMI, ROM_ADDR
  );
endinterface

// File: rtl/z80_bank_map.sv
// ZMC bank registers bk0..bk3 and the combinational Z80 memory address -> ROM byte address map.
module z80_bank_map
  import neogeo_z80io_pkg::*;
#(
  parameter int unsigned ROM_AW = 22
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_load,
  input  logic [1:0]        i_idx,
  input  logic [7:0]        i_data,
  input  logic [15:0]       i_mem_a,
  output logic [ROM_AW-1:0] o_rom_addr
);

  logic [7:0]  r_bk [4];
  logic [31:0] w_full;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bk[0] <= BK0_RST;
      r_bk[1] <= BK1_RST;
      r_bk[2] <= BK2_RST;
      r_bk[3] <= BK3_RST;
    end else if (i_load) begin
      r_bk[i_idx] <= i_data;
    end
  end

  // Windows shrink by half each step; outside them the address passes through unchanged
  always_comb begin
    w_full = {16'h0000, i_mem_a};
    if (i_mem_a >= WIN_BK0 && i_mem_a < WIN_BK1) begin
      w_full = {10'b0, r_bk[0], i_mem_a[13:0]};
    end else if (i_mem_a >= WIN_BK1 && i_mem_a < WIN_BK2) begin
      w_full = {11'b0, r_bk[1], i_mem_a[12:0]};
    end else if (i_mem_a >= WIN_BK2 && i_mem_a < WIN_BK3) begin
      w_full = {12'b0, r_bk[2], i_mem_a[11:0]};
    end else if (i_mem_a >= WIN_BK3 && i_mem_a < WIN_RAM) begin
      w_full = {13'b0, r_bk[3], i_mem_a[10:0]};
    end
  end

  assign o_rom_addr = ROM_AW'(w_full);

endmodule

// File: rtl/z80_io_ctrl.sv
// Z80 sound-CPU I/O port controller: sound-code/reply latches, NMI control, YM2610 select, ZMC banks.
// Optional NEOGEO_Z80IO_OVERRUN_EN adds OVERRUN_CNT, counting sound codes written over a pending one.
module z80_io_ctrl
  import neogeo_z80io_pkg::*;
#(
  parameter int unsigned ROM_AW     = 22,
  parameter bit          NMI_EN_RST = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  z80_io_ctrl_if.slave     bus,
  input  logic             M68K_CODE_WR,
  input  logic [7:0]       M68K_CODE,
  output logic [7:0]       M68K_REPLY,
  output logic             YM_CS_n,
  output logic [1:0]       YM_A,
  input  logic [7:0]       YM_DOUT
`ifdef NEOGEO_Z80IO_OVERRUN_EN
  ,
  output logic [7:0]       OVERRUN_CNT
`endif
);

  logic              w_iord, w_iowr, w_rd_fire, w_wr_fire, w_code_rd;
  logic [2:0]        w_port;
  logic              r_iord, r_iowr;
  logic [7:0]        r_code, r_reply;
  logic              r_pend, r_nmi_en, r_nnmi;
  logic [ROM_AW-1:0] w_rom_addr;

  assign w_iord    = ~bus.nIORQ & ~bus.nRD;
  assign w_iowr    = ~bus.nIORQ & ~bus.nWR;
  assign w_port    = bus.SDA[4:2];
  assign w_rd_fire = w_iord & ~r_iord;
  assign w_wr_fire = w_iowr & ~r_iowr;
  assign w_code_rd = w_rd_fire & (w_port == P_CODE);

  // Edge regs follow the strobe even in reset, so a strobe held across release never fires
  always_ff @(posedge CLK) begin
    r_iord <= w_iord;
    r_iowr <= w_iowr;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_code   <= 8'h00;
      r_reply  <= 8'h00;
      r_pend   <= 1'b0;
      r_nmi_en <= NMI_EN_RST;
      r_nnmi   <= 1'b1;
    end else begin
      if (M68K_CODE_WR) begin
        r_code <= M68K_CODE;
        r_pend <= 1'b1;
      end else if (w_code_rd) begin
        r_pend <= 1'b0;
      end
      if (w_wr_fire && w_port == P_NMI_EN) begin
        r_nmi_en <= 1'b1;
      end else if (w_wr_fire && w_port == P_NMI_DIS) begin
        r_nmi_en <= 1'b0;
      end
      if (w_wr_fire && w_port == P_REPLY) begin
        r_reply <= bus.SDD_OUT;
      end
      r_nnmi <= ~(r_pend & r_nmi_en);
    end
  end

`ifdef NEOGEO_Z80IO_OVERRUN_EN
  logic [7:0] r_overrun;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_overrun <= 8'h00;
    end else if (M68K_CODE_WR && r_pend && !w_code_rd && r_overrun != 8'hFF) begin
      r_overrun <= r_overrun + 8'h01;
    end
  end

  assign OVERRUN_CNT = r_overrun;
`endif

  always_comb begin
    bus.IO_DOUT = 8'hFF;
    case (w_port)
      P_CODE:  bus.IO_DOUT = r_code;
      P_YM:    bus.IO_DOUT = YM_DOUT;
      default: bus.IO_DOUT = 8'hFF;
    endcase
  end

  assign bus.IO_RD_ACT = w_iord;
  assign bus.nNMI      = r_nnmi;
  assign M68K_REPLY    = r_reply;
  assign YM_CS_n       = ~((w_iord | w_iowr) & (w_port == P_YM));
  assign YM_A          = bus.SDA[1:0];

  // Port 0x08+n loads bk[3-n] with the upper address byte
  z80_bank_map #(
    .ROM_AW (ROM_AW)
  ) u_bank_map (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_rd_fire & (w_port == P_BANK)),
    .i_idx      (2'd3 - bus.SDA[1:0]),
    .i_data     (bus.SDA[15:8]),
    .i_mem_a    (bus.MEM_A),
    .o_rom_addr (w_rom_addr)
  );

  assign bus.ROM_ADDR = w_rom_addr;

endmodule
